// File: rtl/demux_1x8_deser.sv
// Sequential 1-to-WIDTH deserializer: LSB-first serial bits assemble into a registered word
// with a valid/ready output. Optional even-parity frame bit when DEMUX_PARITY_EN is defined.
module demux_1x8_deser #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr
);
`ifdef DEMUX_PARITY_EN
    localparam int LAST_I = WIDTH;
`else
    localparam int LAST_I = WIDTH - 1;
`endif
    localparam logic [SEL_W-1:0] LAST = LAST_I[SEL_W-1:0];

    logic [WIDTH-1:0] acc, next_acc;
    logic             accept, at_last, wrap;

    assign at_last  = (sel == LAST);
    // Only the word-completing bit waits on the consumer; partial bits keep flowing.
    assign in_ready = !(at_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !clear;
    assign wrap     = accept && at_last;

    // Accumulator with the current bit merged in; the parity slot (sel==WIDTH) matches no data bit.
    always_comb begin
        next_acc = acc;
        for (int i = 0; i < WIDTH; i++)
            if (sel == SEL_W'(i)) next_acc[i] = in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
            acc <= '0;
        end else if (clear) begin
            sel <= '0;
            acc <= '0;
        end else if (accept) begin
            if (at_last) begin
                sel <= '0;
                acc <= '0;
            end else begin
                sel <= sel + SEL_W'(1);
                acc <= next_acc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (wrap) begin
            out       <= next_acc;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMUX_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       perr_q <= 1'b0;
        else if (wrap) perr_q <= (^acc) ^ in;
    end
    assign out_perr = perr_q;
`else
    assign out_perr = 1'b0;
`endif
endmodule

// File: tb/tb_demux_1x8_deser.sv
// Bench for demux_1x8_deser: queue-based frame model checked every cycle, directed literal
// checks for the key scenarios, then randomized traffic with clear and reset.
module tb_demux_1x8_deser;
    localparam int WIDTH = 8;
    localparam int SEL_W = $clog2(WIDTH+1);
`ifdef DEMUX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             in = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_perr;

    int vectors = 0;
    int errors  = 0;

    demux_1x8_deser #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in(in), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .out_perr(out_perr)
    );

    always #5 clk = ~clk;

    // Model: queue of accepted bits of the current frame plus the output slot.
    logic             mq[$];
    logic [WIDTH-1:0] m_out;
    logic             m_ov, m_perr;

    function automatic logic m_rdy();
        return !(mq.size() == FRAME-1 && m_ov && !out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete(); m_out = '0; m_ov = 1'b0; m_perr = 1'b0;
        end else begin
            logic acc_b;
            acc_b = in_valid && m_rdy() && !clear;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (clear) mq.delete();
            else if (acc_b) begin
                mq.push_back(in);
                if (mq.size() == FRAME) begin
                    int ones;
                    ones = 0;
                    m_out = '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        m_out = m_out | (WIDTH'(mq[i]) << i);
                        ones += int'(mq[i]);
                    end
                    if (FRAME > WIDTH) m_perr = ((ones + int'(mq[WIDTH])) % 2) == 1;
                    m_ov = 1'b1;
                    mq.delete();
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(m_rdy()));
        chk("sel", 64'(sel), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out", 64'(out), 64'(m_out));
        chk("out_perr", 64'(out_perr), 64'(m_perr));
    end

    // Drive one bit; hold it until an edge where in_ready was high.
    task automatic send_bit(input logic b);
        logic rdy;
        int t;
        t = 0;
        in = b; in_valid = 1'b1;
        forever begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            t++;
            if (t > 200) begin
                errors++;
                $display("FAIL send_bit timeout: in_ready stayed %0b, needed 1", in_ready);
                break;
            end
        end
    endtask

    function automatic logic even_par(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    task automatic send_word(input logic [WIDTH-1:0] w, input logic par);
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
        if (FRAME > WIDTH) send_bit(par);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-word
        send_bit(1); send_bit(1); send_bit(1);
        in_valid = 1'b0;
        rst = 1'b1; #1;
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'h00);
        @(posedge clk); #1 rst = 1'b0;

        // Basic assembly 0xA5, valid for one cycle
        out_ready = 1'b1;
        send_word(8'hA5, even_par(8'hA5));
        in_valid = 1'b0;
        chk("a5_valid", 64'(out_valid), 64'd1);
        chk("a5_out", 64'(out), 64'hA5);
        chk("a5_perr", 64'(out_perr), 64'd0);
        @(posedge clk); #1;
        chk("a5_valid_drop", 64'(out_valid), 64'd0);

        // Back-to-back FF then 00
        send_word(8'hFF, even_par(8'hFF));
        chk("ff_out", 64'(out), 64'hFF);
        send_word(8'h00, even_par(8'h00));
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("00_out", 64'(out), 64'h00);
        idle(2);

        // Backpressure: 3C pending, next word stalls on its last bit
        send_word(8'h3C, even_par(8'h3C));
        in_valid = 1'b0;
        out_ready = 1'b0;
        w = 8'hC3;
        for (int i = 0; i < FRAME-1; i++) send_bit(i < WIDTH ? w[i] : even_par(w));
        in = (FRAME > WIDTH) ? even_par(w) : w[WIDTH-1];
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sel", 64'(sel), 64'(FRAME-1));
            chk("bp_hold", 64'(out), 64'h3C);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(in_ready), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("bp_c3", 64'(out), 64'hC3);
        chk("bp_c3_valid", 64'(out_valid), 64'd1);

        // Clear drops the concurrent bit; pending out untouched
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        in = 1'b1; in_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
        chk("clr_sel", 64'(sel), 64'd0);
        chk("clr_pending", 64'(out), 64'hC3);
        chk("clr_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        send_word(8'h0F, even_par(8'h0F));
        in_valid = 1'b0;
        chk("clr_0f", 64'(out), 64'h0F);

`ifdef DEMUX_PARITY_EN
        send_word(8'h01, 1'b1);
        in_valid = 1'b0;
        chk("par_ok", 64'(out_perr), 64'd0);
        send_word(8'h01, 1'b0);
        in_valid = 1'b0;
        chk("par_err", 64'(out_perr), 64'd1);
        chk("par_out", 64'(out), 64'h01);
`endif
        idle(2);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            in        = 1'($urandom);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            clear     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 999) < 2);
            @(posedge clk); #1;
        end
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
